rom_region_loader: RTL and testbench

ROM_REGION_LOADER -- requirements
Module: rom_region_loader

---
 rtl/rom_region_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_rom_region_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_region_loader.sv
// Streams a download byte stream into up to N_REGIONS regions, each routed to BRAM bytes or SDRAM 16-bit words.
// Optional: define LOADER_REORDER_16_EN to honour region_reorder (per-region byte swap of SDRAM words).
module rom_region_loader #(
  parameter int unsigned N_REGIONS = 9,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned CS_W      = 6
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_REGIONS*ADDR_W-1:0]    region_base,
  input  logic [N_REGIONS*ADDR_W-1:0]    region_size,
  input  logic [N_REGIONS-1:0]           region_reorder,
  input  logic [N_REGIONS*CS_W-1:0]      region_cs,
  input  logic                           start,
  input  logic                           dl_valid,
  input  logic [7:0]                     dl_data,
  output logic                           dl_ready,
  output logic                           bram_wr,
  output logic [CS_W-1:0]                bram_cs,
  output logic [ADDR_W-1:0]              bram_addr,
  output logic [7:0]                     bram_data,
  output logic                           sdr_req,
  output logic [ADDR_W-1:0]              sdr_addr,
  output logic [15:0]                    sdr_data,
  input  logic                           sdr_ack,
  output logic [$clog2(N_REGIONS)-1:0]   region_idx,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int unsigned IDX_W = $clog2(N_REGIONS);

  typedef enum logic [1:0] {IDLE, LOAD, SDR_WAIT, DONE} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [ADDR_W-1:0]   r_offset;
  logic [7:0]          r_lo;
  logic                r_pend_adv;
  logic                r_overflow;
  logic                r_dl_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_bram_wr;
  logic [CS_W-1:0]     r_bram_cs;
  logic [ADDR_W-1:0]   r_bram_addr;
  logic [7:0]          r_bram_data;
  logic                r_sdr_req;
  logic [ADDR_W-1:0]   r_sdr_addr;
  logic [15:0]         r_sdr_data;

  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   w_size;
  logic [CS_W-1:0]     w_cs;
  logic                w_reorder;
  logic                w_swap;
  logic                w_last;
  logic                w_accept;
  logic                w_first_found;
  logic [IDX_W-1:0]    w_first_idx;
  logic                w_next_found;
  logic [IDX_W-1:0]    w_next_idx;

  // {dl_ready, busy, done} for a given state
  function automatic logic [2:0] st_flags(input state_t s);
    case (s)
      LOAD:     st_flags = 3'b110;
      SDR_WAIT: st_flags = 3'b010;
      DONE:     st_flags = 3'b101;
      default:  st_flags = 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] pack(input logic [7:0] ev, input logic [7:0] od, input logic sw);
    pack = sw ? {ev, od} : {od, ev};
  endfunction

  // Current-region fields and the first/next nonzero-size region lookups
  always_comb begin
    w_base        = '0;
    w_size        = '0;
    w_cs          = '0;
    w_reorder     = 1'b0;
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int i = 0; i < int'(N_REGIONS); i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_base    = region_base[i*ADDR_W +: ADDR_W];
        w_size    = region_size[i*ADDR_W +: ADDR_W];
        w_cs      = region_cs[i*CS_W +: CS_W];
        w_reorder = region_reorder[i];
      end
    end
    for (int i = int'(N_REGIONS) - 1; i >= 0; i--) begin
      if (region_size[i*ADDR_W +: ADDR_W] != '0) begin
        w_first_found = 1'b1;
        w_first_idx   = IDX_W'(i);
        if (IDX_W'(i) > r_idx) begin
          w_next_found = 1'b1;
          w_next_idx   = IDX_W'(i);
        end
      end
    end
  end

`ifdef LOADER_REORDER_16_EN
  assign w_swap = w_reorder;
`else
  logic w_unused_reorder;
  assign w_unused_reorder = w_reorder;
  assign w_swap = 1'b0;
`endif

  assign w_last   = (r_offset == w_size - ADDR_W'(1));
  assign w_accept = dl_valid && r_dl_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_offset    <= '0;
      r_lo        <= '0;
      r_pend_adv  <= 1'b0;
      r_overflow  <= 1'b0;
      r_dl_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bram_wr   <= 1'b0;
      r_bram_cs   <= '0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
      r_sdr_req   <= 1'b0;
      r_sdr_addr  <= '0;
      r_sdr_data  <= '0;
    end else begin
      r_bram_wr <= 1'b0;
      if (start) begin
        // Restart from any state; a pending SDRAM word is dropped
        r_offset   <= '0;
        r_overflow <= 1'b0;
        r_sdr_req  <= 1'b0;
        r_pend_adv <= 1'b0;
        r_idx      <= w_first_found ? w_first_idx : '0;
        r_state    <= w_first_found ? LOAD : DONE;
        {r_dl_ready, r_busy, r_done} <= st_flags(w_first_found ? LOAD : DONE);
      end else begin
        case (r_state)
          LOAD: begin
            if (w_accept) begin
              if (w_cs != '0) begin
                r_bram_wr   <= 1'b1;
                r_bram_cs   <= w_cs;
                r_bram_addr <= r_offset;
                r_bram_data <= dl_data;
                if (w_last) begin
                  r_offset <= '0;
                  r_idx    <= w_next_found ? w_next_idx : r_idx;
                  r_state  <= w_next_found ? LOAD : DONE;
                  {r_dl_ready, r_busy, r_done} <= st_flags(w_next_found ? LOAD : DONE);
                end else begin
                  r_offset <= r_offset + ADDR_W'(1);
                end
              end else if (!r_offset[0] && !w_last) begin
                r_lo     <= dl_data;
                r_offset <= r_offset + ADDR_W'(1);
              end else begin
                // Odd byte completes a word; an even last byte flushes with a zero pad
                r_sdr_req  <= 1'b1;
                r_pend_adv <= w_last;
                r_state    <= SDR_WAIT;
                {r_dl_ready, r_busy, r_done} <= st_flags(SDR_WAIT);
                if (r_offset[0]) begin
                  r_sdr_addr <= w_base + r_offset - ADDR_W'(1);
                  r_sdr_data <= pack(r_lo, dl_data, w_swap);
                end else begin
                  r_lo       <= dl_data;
                  r_sdr_addr <= w_base + r_offset;
                  r_sdr_data <= pack(dl_data, 8'h00, w_swap);
                end
                if (!w_last) r_offset <= r_offset + ADDR_W'(1);
              end
            end
          end
          SDR_WAIT: begin
            if (sdr_ack) begin
              r_sdr_req  <= 1'b0;
              r_pend_adv <= 1'b0;
              if (r_pend_adv) begin
                r_offset <= '0;
                r_idx    <= w_next_found ? w_next_idx : r_idx;
                r_state  <= w_next_found ? LOAD : DONE;
                {r_dl_ready, r_busy, r_done} <= st_flags(w_next_found ? LOAD : DONE);
              end else begin
                r_state <= LOAD;
                {r_dl_ready, r_busy, r_done} <= st_flags(LOAD);
              end
            end
          end
          DONE: begin
            if (w_accept) r_overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dl_ready   = r_dl_ready;
  assign bram_wr    = r_bram_wr;
  assign bram_cs    = r_bram_cs;
  assign bram_addr  = r_bram_addr;
  assign bram_data  = r_bram_data;
  assign sdr_req    = r_sdr_req;
  assign sdr_addr   = r_sdr_addr;
  assign sdr_data   = r_sdr_data;
  assign region_idx = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_region_loader.sv
// Scoreboard bench for rom_region_loader: stimulus pushes expected writes, a monitor pops on bram_wr / new sdr_req.
module tb_rom_region_loader;

  localparam int unsigned N  = 9;
  localparam int unsigned AW = 25;
  localparam int unsigned CW = 6;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*AW-1:0] region_base;
  logic [N*AW-1:0] region_size;
  logic [N-1:0]    region_reorder;
  logic [N*CW-1:0] region_cs;
  logic            start;
  logic            dl_valid;
  logic [7:0]      dl_data;
  logic            dl_ready;
  logic            bram_wr;
  logic [CW-1:0]   bram_cs;
  logic [AW-1:0]   bram_addr;
  logic [7:0]      bram_data;
  logic            sdr_req;
  logic [AW-1:0]   sdr_addr;
  logic [15:0]     sdr_data;
  logic            sdr_ack;
  logic [3:0]      region_idx;
  logic            busy;
  logic            done;
  logic            overflow;

  rom_region_loader #(.N_REGIONS(N), .ADDR_W(AW), .CS_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .region_base(region_base), .region_size(region_size),
    .region_reorder(region_reorder), .region_cs(region_cs),
    .start(start), .dl_valid(dl_valid), .dl_data(dl_data), .dl_ready(dl_ready),
    .bram_wr(bram_wr), .bram_cs(bram_cs), .bram_addr(bram_addr), .bram_data(bram_data),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_ack(sdr_ack),
    .region_idx(region_idx), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_sdr;
    logic [CW-1:0] cs;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic ack_en  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bram(input logic [CW-1:0] cs, input logic [AW-1:0] a, input logic [7:0] d);
    exp_t e;
    e.is_sdr = 1'b0; e.cs = cs; e.addr = a; e.data = {8'h00, d};
    q.push_back(e);
  endtask

  task automatic push_sdr(input logic [AW-1:0] a, input logic [15:0] d);
    exp_t e;
    e.is_sdr = 1'b1; e.cs = '0; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic set_region(input int i, input logic [AW-1:0] base, input logic [AW-1:0] size,
                            input logic [CW-1:0] cs, input logic ro);
    region_base[i*AW +: AW] = base;
    region_size[i*AW +: AW] = size;
    region_cs[i*CW +: CW]   = cs;
    region_reorder[i]       = ro;
  endtask

  task automatic clear_regions();
    region_base = '0; region_size = '0; region_cs = '0; region_reorder = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one byte and hold it until dl_ready lets it through
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    dl_valid = 1'b1; dl_data = b;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (dl_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    dl_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 60 && (q.size() != 0 || sdr_req); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
  endtask

  // SDRAM model: ack sampled 3 cycles after req rises
  initial begin
    sdr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && sdr_req) begin
        repeat (2) @(negedge clk);
        if (ack_en && sdr_req) begin
          sdr_ack = 1'b1;
          @(negedge clk);
          sdr_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops one expectation per output event
  initial begin
    logic          prev_req  = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [15:0]   prev_data = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (bram_wr) begin
        if (q.size() == 0) chk("unexpected_bram_wr", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("bram_kind", 32'(e.is_sdr), 32'd0);
          chk("bram_cs",   32'(bram_cs),   32'(e.cs));
          chk("bram_addr", 32'(bram_addr), 32'(e.addr));
          chk("bram_data", 32'(bram_data), 32'(e.data));
        end
      end
      if (sdr_req && !prev_req) begin
        if (q.size() == 0) chk("unexpected_sdr_req", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sdr_kind", 32'(e.is_sdr), 32'd1);
          chk("sdr_addr", 32'(sdr_addr), 32'(e.addr));
          chk("sdr_data", 32'(sdr_data), 32'(e.data));
        end
      end
      if (sdr_req) chk("dl_ready_in_wait", 32'(dl_ready), 32'd0);
      if (sdr_req && prev_req) begin
        chk("sdr_addr_stable", 32'(sdr_addr), 32'(prev_addr));
        chk("sdr_data_stable", 32'(sdr_data), 32'(prev_data));
      end
      prev_req = sdr_req; prev_addr = sdr_addr; prev_data = sdr_data;
    end
  end

  initial begin
    logic [15:0] w0, w1;
    reset_n = 1'b0; start = 1'b0; dl_valid = 1'b0; dl_data = '0;
    clear_regions();
    repeat (3) @(negedge clk);
    chk("rst_dl_ready", 32'(dl_ready), 32'd0);
    chk("rst_outputs",  32'({bram_wr, sdr_req, busy, done, overflow}), 32'd0);
    chk("rst_sdr_addr", 32'(sdr_addr), 32'd0);
    chk("rst_idx",      32'(region_idx), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_dl_ready", 32'(dl_ready), 32'd0);

    // BRAM region of 4 bytes
    set_region(0, 25'h0, 25'd4, 6'b000001, 1'b0);
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    push_bram(6'd1, 25'd0, 8'h11); push_bram(6'd1, 25'd1, 8'h22);
    push_bram(6'd1, 25'd2, 8'h33); push_bram(6'd1, 25'd3, 8'h44);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_drain("t1_drain");
    chk("t1_done", 32'({done, busy, overflow}), 32'b100);

    // SDRAM region, reorder=0 then reorder=1
    for (int ro = 0; ro < 2; ro++) begin
      clear_regions();
      set_region(0, 25'h40000, 25'd4, 6'd0, 1'(ro));
`ifdef LOADER_REORDER_16_EN
      w0 = (ro == 1) ? 16'hAABB : 16'hBBAA;
      w1 = (ro == 1) ? 16'hCCDD : 16'hDDCC;
`else
      w0 = 16'hBBAA;
      w1 = 16'hDDCC;
`endif
      pulse_start();
      push_sdr(25'h40000, w0); push_sdr(25'h40002, w1);
      send_byte(8'hAA);
      chk("t2_even_no_req", 32'(sdr_req), 32'd0);
      send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      wait_drain("t2_drain");
      chk("t2_done", 32'(done), 32'd1);
    end

    // Odd-size SDRAM region flushes a padded word
    clear_regions();
    set_region(0, 25'h200, 25'd3, 6'd0, 1'b0);
    pulse_start();
    push_sdr(25'h200, 16'h0201); push_sdr(25'h202, 16'h0003);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wait_drain("t3_drain");
    chk("t3_done", 32'(done), 32'd1);

    // Zero-size skip, then overflow in DONE
    clear_regions();
    set_region(0, 25'h100, 25'd2, 6'd0, 1'b0);
    set_region(2, 25'h0,   25'd1, 6'b000100, 1'b0);
    pulse_start();
    chk("t4_idx0", 32'(region_idx), 32'd0);
    push_sdr(25'h100, 16'h0201); push_bram(6'd4, 25'd0, 8'h03);
    send_byte(8'h01); send_byte(8'h02);
    chk("t4_idx_pending", 32'(region_idx), 32'd0);
    send_byte(8'h03);
    chk("t4_idx2", 32'(region_idx), 32'd2);
    chk("t4_done_no_ovf", 32'({done, overflow}), 32'b10);
    send_byte(8'h04);
    chk("t4_overflow", 32'(overflow), 32'd1);
    wait_drain("t4_drain");

    // Restart during SDR_WAIT
    clear_regions();
    set_region(0, 25'h40000, 25'd4, 6'd0, 1'b0);
    ack_en = 1'b0;
    pulse_start();
    chk("t5_ovf_cleared", 32'(overflow), 32'd0);
    push_sdr(25'h40000, 16'hBBAA);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("t5_req_held", 32'({sdr_req, dl_ready}), 32'b10);
    pulse_start();
    chk("t5_req_dropped", 32'(sdr_req), 32'd0);
    chk("t5_idx", 32'(region_idx), 32'd0);
    chk("t5_load", 32'({busy, dl_ready}), 32'b11);
    ack_en = 1'b1;
    push_sdr(25'h40000, 16'h2211); push_sdr(25'h40002, 16'h4433);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_drain("t5_drain");
    chk("t5_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
